// File: rtl/ccff_bitstream_loader.sv
// Feeds the fabric configuration chain: shifts stream words MSB-first onto ccff_head,
// counts exactly CHAIN_LEN enabled shifts, then checks that the first bit reached ccff_tail.
//
// state  | meaning
// IDLE   | waiting for start after reset
// FETCH  | data_ready high, waiting for the next word
// SHIFT  | one bit per cycle onto ccff_head with ccff_shift_en
// SETTLE | idle cycle after the last enabled chain edge
// CHECK  | sample ccff_tail against the first bit shifted
// DONE   | load finished, done/err held until the next start
module ccff_bitstream_loader #(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 1024
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic [WORD_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int BIT_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CHAIN_LEN - 1);
  localparam logic [BIT_W-1:0] BITS_FULL = BIT_W'(WORD_W);
  localparam logic [BIT_W-1:0] BITS_ONE  = BIT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SHIFT,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WORD_W-1:0] sr;
  logic [BIT_W-1:0]  bits_left;
  logic [CNT_W-1:0]  cnt;
  logic              first_bit;
  logic              start_ok;
  logic              chain_last;
  logic              word_last;

  assign start_ok   = start && ((state == S_IDLE) || (state == S_DONE));
  assign chain_last = (cnt == CNT_LAST);
  assign word_last  = (bits_left == BITS_ONE);

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    data_ready = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        data_ready = 1'b1;
        if (data_valid) state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        // Chain length wins over word boundary: leftover low bits of the final word are dropped.
        if (chain_last)     state_nxt = S_SETTLE;
        else if (word_last) state_nxt = S_FETCH;
      end
      S_SETTLE: state_nxt = S_CHECK;
      S_CHECK:  state_nxt = S_DONE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      sr            <= '0;
      bits_left     <= '0;
      cnt           <= '0;
      first_bit     <= 1'b0;
      ccff_head     <= 1'b0;
      ccff_shift_en <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      ccff_shift_en <= 1'b0;
      if (start_ok) begin
        busy <= 1'b1;
        done <= 1'b0;
        err  <= 1'b0;
        cnt  <= '0;
      end
      case (state)
        S_FETCH: begin
          if (data_valid) begin
            sr        <= data_in;
            bits_left <= BITS_FULL;
          end
        end
        S_SHIFT: begin
          ccff_head     <= sr[WORD_W-1];
          ccff_shift_en <= 1'b1;
          sr            <= sr << 1;
          bits_left     <= bits_left - BITS_ONE;
          cnt           <= cnt + CNT_W'(1);
          if (cnt == '0) first_bit <= sr[WORD_W-1];
        end
        S_CHECK: begin
          err  <= (ccff_tail != first_bit);
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Scoreboard bench for ccff_bitstream_loader: two lanes (20-FF and 16-FF chains),
// each with its own behavioural chain model, randomized loads and a negedge monitor.
module tb_ccff_bitstream_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit fin [2];

  task automatic check(input int cl, input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL cl%0d_%s actual=%0d required=%0d", cl, name, act, exp);
    end
  endtask

  task automatic tfail(input int cl, input string name);
    checks++;
    failures++;
    $display("FAIL cl%0d_%s actual=timeout required=event", cl, name);
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int CL = (g == 0) ? 20 : 16;
    localparam int NW = (CL + 7) / 8;

    logic          rst, start, data_valid, invert_tail, tail;
    logic [7:0]    data_in;
    logic          data_ready, head, shift_en, busy, done, err;
    logic [CL-1:0] chain;

    ccff_bitstream_loader #(.WORD_W(8), .CHAIN_LEN(CL)) u_dut (
      .prog_clk      (clk),
      .prog_reset    (rst),
      .start         (start),
      .data_in       (data_in),
      .data_valid    (data_valid),
      .data_ready    (data_ready),
      .ccff_head     (head),
      .ccff_shift_en (shift_en),
      .ccff_tail     (tail),
      .busy          (busy),
      .done          (done),
      .err           (err)
    );

    // Chain model: index 0 sits at the head, CL-1 drives the tail.
    always @(posedge clk) if (shift_en) chain <= {chain[CL-2:0], head};
    assign tail = chain[CL-1] ^ invert_tail;

    bit            exp_bits  [$];
    bit            exp_err   [$];
    logic [CL-1:0] exp_chain [$];
    int            exp_words [$];

    int cyc = 0, last_pulse = 0, pulses_load = 0, words_load = 0, xfers = 0;
    bit prev_done = 1'b0;

    always @(negedge clk) begin
      cyc++;
      if (rst || (start && !busy)) begin
        pulses_load = 0;
        words_load  = 0;
      end
      if (!busy) check(CL, "ready_when_idle", data_ready, 0);
      if (data_valid && data_ready) begin
        words_load++;
        xfers++;
      end
      if (shift_en) begin
        pulses_load++;
        last_pulse = cyc;
        if (exp_bits.size() == 0) check(CL, "extra_pulse", 1, 0);
        else                      check(CL, "head_bit", head, exp_bits.pop_front());
      end
      if (done && !prev_done) begin
        check(CL, "busy_at_done", busy, 0);
        check(CL, "done_latency", cyc - last_pulse, 2);
        check(CL, "pulse_count", pulses_load, CL);
        if (exp_err.size() == 0) begin
          check(CL, "unexpected_done", 1, 0);
        end else begin
          check(CL, "err", err, exp_err.pop_front());
          check(CL, "chain", int'(chain), int'(exp_chain.pop_front()));
          check(CL, "words_accepted", words_load, exp_words.pop_front());
        end
      end
      prev_done = done;
    end

    logic [7:0]    words [NW];
    logic [CL-1:0] ev;
    int  k, gap, gap_w, abort_at, snap;
    bit  inv, junk, fixed, aborted, b;

    initial begin
      rst = 1'b1; start = 1'b0; data_valid = 1'b0; data_in = '0; invert_tail = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check(CL, "rst_head", head, 0);
      check(CL, "rst_shift_en", shift_en, 0);
      check(CL, "rst_busy", busy, 0);
      check(CL, "rst_done", done, 0);
      check(CL, "rst_err", err, 0);
      check(CL, "rst_ready", data_ready, 0);
      @(posedge clk); #1 rst = 1'b0;

      for (int s = 0; s < 12; s++) begin
        fixed    = (s == 0);
        gap      = (s == 1) ? 14 : ((s < 5) ? 0 : $urandom_range(0, 12));
        inv      = (s == 2) || (s >= 6 && $urandom_range(0, 3) == 0);
        junk     = (s == 5) || (s >= 6 && $urandom_range(0, 1) == 1);
        abort_at = (s == 3) ? ((CL == 20) ? 10 : 6) : 0;
        for (int w = 0; w < NW; w++)
          words[w] = fixed ? ((w == 0) ? 8'hA5 : (w == 1) ? 8'h3C : 8'hF0) : 8'($urandom);

        check(CL, "leftover_bits", exp_bits.size(), 0);
        exp_bits.delete();
        for (int i = 0; i < CL; i++) begin
          b = words[i / 8][7 - (i % 8)];
          exp_bits.push_back(b);
          ev[CL-1-i] = b;
        end
        exp_chain.push_back(ev);
        exp_err.push_back(inv);
        exp_words.push_back(NW);
        invert_tail = inv;

        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        check(CL, "start_busy", busy, 1);
        check(CL, "start_clears_done", done, 0);
        check(CL, "start_clears_err", err, 0);

        aborted = 1'b0;
        for (int w = 0; w < NW && !aborted; w++) begin
          if (abort_at > 0 && w * 8 >= abort_at) begin
            k = 0;
            while (pulses_load < abort_at && k < 100) begin
              @(posedge clk);
              k++;
            end
            if (pulses_load < abort_at) tfail(CL, "abort_wait");
            #1 rst = 1'b1;
            @(posedge clk); #1 rst = 1'b0;
            @(negedge clk);
            check(CL, "abort_head", head, 0);
            check(CL, "abort_shift_en", shift_en, 0);
            check(CL, "abort_busy", busy, 0);
            check(CL, "abort_done", done, 0);
            check(CL, "abort_err", err, 0);
            check(CL, "abort_ready", data_ready, 0);
            exp_bits.delete();
            exp_err.delete();
            exp_chain.delete();
            exp_words.delete();
            aborted = 1'b1;
          end else begin
            gap_w = (w == 0) ? 0 : gap;
            repeat (gap_w) begin
              @(posedge clk); #1 data_valid = 1'b0; start = junk;
            end
            @(posedge clk); #1 start = 1'b0; data_valid = 1'b1; data_in = words[w];
            k = 0;
            do begin
              @(negedge clk);
              k++;
            end while (!data_ready && k < 200);
            if (!data_ready) tfail(CL, "ready_wait");
            @(posedge clk); #1 data_valid = 1'b0; data_in = 8'($urandom);
          end
        end

        if (!aborted) begin
          k = 0;
          while (!done && k < 200) begin
            @(negedge clk);
            k++;
          end
          if (!done) tfail(CL, "done_wait");
          if (junk) begin
            snap = xfers;
            @(posedge clk); #1 data_valid = 1'b1; data_in = 8'($urandom);
            repeat (5) @(posedge clk);
            #1 data_valid = 1'b0;
            @(negedge clk);
            check(CL, "no_xfer_in_done", xfers, snap);
            check(CL, "done_held", done, 1);
          end
        end
      end
      check(CL, "final_leftover_bits", exp_bits.size(), 0);
      fin[g] = 1'b1;
    end
  end

  initial begin
    int k;
    k = 0;
    while (!(fin[0] && fin[1]) && k < 50000) begin
      @(posedge clk);
      k++;
    end
    if (!(fin[0] && fin[1])) begin
      checks++;
      failures++;
      $display("FAIL tb_timeout actual=unfinished required=finished");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
